// File: rtl/tournament_predictor_param.sv
// Tournament branch predictor: local, global (gshare or pure history) and chooser
// counter tables, initialised by a post-reset sweep and trained on branch resolution.
module tournament_predictor_param #(
  parameter int LHT_BITS = 4,
  parameter int GHR_BITS = 8,
  parameter int CTR_BITS = 2,
  parameter int GSHARE   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        branch_decode_sig,
  input  logic [31:0] pc_branch_addr,
  input  logic [31:0] offset,
  input  logic        update_valid,
  input  logic        actual_branch_decision,
  output logic        prediction,
  output logic [31:0] out_branch_addr,
  output logic        mispredict,
  output logic        ready
);

  localparam int IDX_BITS = (LHT_BITS > GHR_BITS) ? LHT_BITS : GHR_BITS;
  localparam logic [IDX_BITS-1:0] IDX_LAST = {IDX_BITS{1'b1}};
  localparam logic [IDX_BITS-1:0] IDX_ONE  = {{(IDX_BITS-1){1'b0}}, 1'b1};
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_ZERO = {CTR_BITS{1'b0}};
  localparam logic [CTR_BITS-1:0] CTR_ONE  = {{(CTR_BITS-1){1'b0}}, 1'b1};
  localparam logic [CTR_BITS-1:0] CTR_WT   = {1'b1, {(CTR_BITS-1){1'b0}}};
  localparam logic [CTR_BITS-1:0] CTR_WL   = {1'b0, {(CTR_BITS-1){1'b1}}};

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_e;

  function automatic logic [CTR_BITS-1:0] ctr_step(input logic [CTR_BITS-1:0] c, input logic up);
    if (up) return (c == CTR_MAX) ? c : c + CTR_ONE;
    else    return (c == CTR_ZERO) ? c : c - CTR_ONE;
  endfunction

  state_e                state_q;
  logic [IDX_BITS-1:0]   init_idx_q;
  logic [GHR_BITS-1:0]   ghr_q, ghr_d;
  logic                  pending_q, pending_d;
  logic [LHT_BITS-1:0]   rec_li_q;
  logic [GHR_BITS-1:0]   rec_gi_q;
  logic                  rec_lp_q, rec_gp_q, rec_pred_q;

  logic [CTR_BITS-1:0]   lht_q [0:(1<<LHT_BITS)-1];
  logic [CTR_BITS-1:0]   pht_q [0:(1<<GHR_BITS)-1];
  logic [CTR_BITS-1:0]   cht_q [0:(1<<LHT_BITS)-1];

  logic                  run_s, capture_s, update_s;
  logic [LHT_BITS-1:0]   li_s;
  logic [GHR_BITS-1:0]   gi_s;
  logic                  local_p_s, global_p_s, sel_s, pred_s;

  assign run_s      = (state_q == S_RUN);
  assign li_s       = pc_branch_addr[LHT_BITS+1:2];
  assign gi_s       = (GSHARE != 0) ? (ghr_q ^ pc_branch_addr[GHR_BITS+1:2]) : ghr_q;
  assign local_p_s  = lht_q[li_s][CTR_BITS-1];
  assign global_p_s = pht_q[gi_s][CTR_BITS-1];
  assign sel_s      = cht_q[li_s][CTR_BITS-1];
  assign pred_s     = run_s & branch_decode_sig & (sel_s ? global_p_s : local_p_s);
  assign capture_s  = run_s & branch_decode_sig;
  assign update_s   = run_s & update_valid & pending_q;

  assign prediction      = pred_s;
  assign ready           = run_s;
  assign mispredict      = update_valid & pending_q & run_s & (rec_pred_q != actual_branch_decision);
  assign out_branch_addr = pc_branch_addr + offset;

  // History is non-speculative; a same-edge capture keeps the record pending.
  always_comb begin
    ghr_d     = ghr_q;
    pending_d = pending_q;
    if (update_s) begin
      ghr_d     = {ghr_q[GHR_BITS-2:0], actual_branch_decision};
      pending_d = 1'b0;
    end else begin
      ghr_d     = ghr_q;
    end
    if (capture_s) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_d;
    end
  end

  // Control FSM: init sweep, history and in-flight record.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_INIT;
      init_idx_q <= {IDX_BITS{1'b0}};
      ghr_q      <= {GHR_BITS{1'b0}};
      pending_q  <= 1'b0;
      rec_li_q   <= {LHT_BITS{1'b0}};
      rec_gi_q   <= {GHR_BITS{1'b0}};
      rec_lp_q   <= 1'b0;
      rec_gp_q   <= 1'b0;
      rec_pred_q <= 1'b0;
    end else begin
      case (state_q)
        S_INIT: begin
          init_idx_q <= init_idx_q + IDX_ONE;
          if (init_idx_q == IDX_LAST) state_q <= S_RUN;
        end
        S_RUN: begin
          ghr_q     <= ghr_d;
          pending_q <= pending_d;
          if (capture_s) begin
            rec_li_q   <= li_s;
            rec_gi_q   <= gi_s;
            rec_lp_q   <= local_p_s;
            rec_gp_q   <= global_p_s;
            rec_pred_q <= pred_s;
          end
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  // Table storage has no reset; the INIT sweep writes every entry instead.
  always_ff @(posedge clk) begin
    if (state_q == S_INIT) begin
      lht_q[init_idx_q[LHT_BITS-1:0]] <= CTR_WT;
      pht_q[init_idx_q[GHR_BITS-1:0]] <= CTR_WT;
      cht_q[init_idx_q[LHT_BITS-1:0]] <= CTR_WL;
    end else if (update_s) begin
      lht_q[rec_li_q] <= ctr_step(lht_q[rec_li_q], actual_branch_decision);
      pht_q[rec_gi_q] <= ctr_step(pht_q[rec_gi_q], actual_branch_decision);
      if (rec_lp_q != rec_gp_q)
        cht_q[rec_li_q] <= ctr_step(cht_q[rec_li_q], rec_gp_q == actual_branch_decision);
    end
  end

endmodule

// File: tb/tb_tournament_predictor_param.sv
// Bench for tournament_predictor_param: default instance against a behavioural
// model, plus a small-table instance (LHT 6, GHR 4, CTR 3, pure global).
module tb_tournament_predictor_param;

  logic        clk = 1'b0;
  logic        reset_s = 1'b1;
  logic        dec_s = 1'b0, uv_s = 1'b0, act_s = 1'b0;
  logic [31:0] pc_s = 32'h0, off_s = 32'h0;
  logic        pred_s, mis_s, rdy_s;
  logic [31:0] addr_s;

  logic        reset2_s = 1'b1;
  logic        dec2_s = 1'b0, uv2_s = 1'b0, act2_s = 1'b0;
  logic [31:0] pc2_s = 32'h0, off2_s = 32'h0000_0100;
  logic        pred2_s, mis2_s, rdy2_s;
  logic [31:0] addr2_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tournament_predictor_param dut (
    .clk(clk), .reset(reset_s), .branch_decode_sig(dec_s), .pc_branch_addr(pc_s),
    .offset(off_s), .update_valid(uv_s), .actual_branch_decision(act_s),
    .prediction(pred_s), .out_branch_addr(addr_s), .mispredict(mis_s), .ready(rdy_s));

  tournament_predictor_param #(.LHT_BITS(6), .GHR_BITS(4), .CTR_BITS(3), .GSHARE(0)) dut_small (
    .clk(clk), .reset(reset2_s), .branch_decode_sig(dec2_s), .pc_branch_addr(pc2_s),
    .offset(off2_s), .update_valid(uv2_s), .actual_branch_decision(act2_s),
    .prediction(pred2_s), .out_branch_addr(addr2_s), .mispredict(mis2_s), .ready(rdy2_s));

  // Behavioural model of the default instance (16-entry local/chooser, 256-entry pattern, 2-bit)
  int m_lht [16];
  int m_pht [256];
  int m_cht [16];
  int m_ghr, m_icnt, m_rli, m_rgi;
  bit m_run, m_pend, m_rlp, m_rgp, m_rpred;
  bit exp_pred, exp_mis, exp_rdy;
  logic [31:0] exp_addr;

  function automatic int sat(input int c, input bit up);
    if (up) return (c < 3) ? c + 1 : 3;
    return (c > 0) ? c - 1 : 0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin m_lht[i] = 2; m_cht[i] = 1; end
    for (int i = 0; i < 256; i++) m_pht[i] = 2;
    m_ghr = 0; m_icnt = 0; m_run = 0; m_pend = 0;
  endtask

  task automatic m_lookup(output int li, output int gi, output bit lp, output bit gp, output bit p);
    li = int'((pc_s >> 2) & 32'h0000_000F);
    gi = int'((pc_s >> 2) & 32'h0000_00FF) ^ m_ghr;
    lp = (m_lht[li] >= 2);
    gp = (m_pht[gi] >= 2);
    p  = m_run && dec_s && ((m_cht[li] >= 2) ? gp : lp);
  endtask

  task automatic m_expect();
    int li, gi; bit lp, gp, p;
    m_lookup(li, gi, lp, gp, p);
    exp_pred = p;
    exp_mis  = m_run && uv_s && m_pend && (m_rpred != act_s);
    exp_rdy  = m_run;
    exp_addr = pc_s + off_s;
  endtask

  task automatic m_edge();
    int li, gi; bit lp, gp, p;
    if (reset_s) begin m_reset(); return; end
    if (!m_run) begin
      m_icnt++;
      if (m_icnt == 256) m_run = 1;
      return;
    end
    m_lookup(li, gi, lp, gp, p);
    if (uv_s && m_pend) begin
      m_lht[m_rli] = sat(m_lht[m_rli], act_s);
      m_pht[m_rgi] = sat(m_pht[m_rgi], act_s);
      if (m_rlp != m_rgp) m_cht[m_rli] = sat(m_cht[m_rli], m_rgp == act_s);
      m_ghr  = ((m_ghr << 1) | int'(act_s)) & 255;
      m_pend = 0;
    end
    if (dec_s) begin
      m_rli = li; m_rgi = gi; m_rlp = lp; m_rgp = gp; m_rpred = p; m_pend = 1;
    end
  endtask

  task automatic drive(input bit d, input logic [31:0] p, input logic [31:0] o, input bit u, input bit a);
    dec_s = d; pc_s = p; off_s = o; uv_s = u; act_s = a;
    @(negedge clk);
    m_expect();
  endtask

  task automatic tick();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic test_reset();
    reset_s = 1'b1;
    m_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h40, 32'h4, 1'b1, 1'b0);
      checks++;
      if (rdy_s !== 1'b0 || pred_s !== 1'b0 || mis_s !== 1'b0) begin
        errors++; $display("FAIL reset_outputs: got rdy=%b pred=%b mis=%b expected 0 0 0", rdy_s, pred_s, mis_s);
      end
      tick();
    end
    reset_s = 1'b0;
    for (int i = 0; i < 256; i++) begin
      drive(1'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom));
      checks++;
      if (rdy_s !== 1'b0 || pred_s !== 1'b0 || mis_s !== 1'b0) begin
        errors++; $display("FAIL init_quiet cycle %0d: got rdy=%b pred=%b mis=%b expected 0 0 0", i, rdy_s, pred_s, mis_s);
      end
      tick();
    end
    drive(1'b1, 32'h40, 32'h10, 1'b0, 1'b0);
    checks++;
    if (rdy_s !== 1'b1 || pred_s !== 1'b1 || addr_s !== 32'h50) begin
      errors++; $display("FAIL first_predict: got rdy=%b pred=%b addr=%h expected 1 1 00000050", rdy_s, pred_s, addr_s);
    end
    tick();
  endtask

  task automatic test_local_sat();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 32'h40, 32'h0, 1'b0, 1'b0);
      checks++;
      if (pred_s !== exp_pred || pred_s !== (k == 0)) begin
        errors++; $display("FAIL local_sat_pred %0d: got %b expected %b", k, pred_s, (k == 0));
      end
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checks++;
      if (mis_s !== exp_mis || mis_s !== (k == 0)) begin
        errors++; $display("FAIL local_sat_mis %0d: got %b expected %b", k, mis_s, (k == 0));
      end
      tick();
    end
  endtask

  task automatic test_chooser();
    for (int it = 0; it < 20; it++) begin
      for (int s = 0; s < 2; s++) begin
        bit outcome;
        outcome = (s == 0);
        drive(1'b1, 32'h80, 32'h4, 1'b0, 1'b0);
        checks++;
        if (pred_s !== exp_pred || (it >= 12 && pred_s !== outcome)) begin
          errors++; $display("FAIL chooser_pred it%0d s%0d: got %b expected %b", it, s, pred_s, exp_pred);
        end
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1, outcome);
        checks++;
        if (mis_s !== exp_mis || (it >= 12 && mis_s !== 1'b0)) begin
          errors++; $display("FAIL chooser_mis it%0d s%0d: got %b expected %b", it, s, mis_s, exp_mis);
        end
        tick();
      end
    end
  endtask

  task automatic test_same_cycle();
    bit a;
    drive(1'b1, 32'h44, 32'h0, 1'b0, 1'b0);
    tick();
    for (int r = 0; r < 4; r++) begin
      a = 1'(r & 1) ^ 1'b1;
      drive(1'b1, 32'h44, 32'h0, 1'b1, a);
      checks++;
      if (pred_s !== exp_pred || mis_s !== exp_mis) begin
        errors++; $display("FAIL same_cycle r%0d: got pred=%b mis=%b expected %b %b", r, pred_s, mis_s, exp_pred, exp_mis);
      end
      tick();
    end
    a = ~m_rpred;
    drive(1'b0, 32'h0, 32'h0, 1'b1, a);
    checks++;
    if (mis_s !== 1'b1) begin
      errors++; $display("FAIL same_cycle_pending: got mis=%b expected 1", mis_s);
    end
    tick();
  endtask

  task automatic test_no_pending();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    checks++;
    if (mis_s !== 1'b0) begin
      errors++; $display("FAIL no_pending_mis: got %b expected 0", mis_s);
    end
    tick();
    drive(1'b1, 32'h44, 32'h0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h48, 32'h0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, ~m_rpred);
    checks++;
    if (mis_s !== 1'b1) begin
      errors++; $display("FAIL newer_record_mis: got %b expected 1", mis_s);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h40 + 32'(i * 4), 32'h0, 1'b0, 1'b0);
      checks++;
      if (pred_s !== exp_pred) begin
        errors++; $display("FAIL newer_record_pred %0d: got %b expected %b", i, pred_s, exp_pred);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] p;
      p = ($urandom_range(0, 3) == 0) ? $urandom : (32'h1000 + 32'($urandom_range(0, 7) << 2));
      drive(1'($urandom), p, $urandom, 1'($urandom), 1'($urandom));
      checks++;
      if (pred_s !== exp_pred || mis_s !== exp_mis || rdy_s !== exp_rdy || addr_s !== exp_addr) begin
        errors++; $display("FAIL random %0d: got pred=%b mis=%b rdy=%b addr=%h expected %b %b %b %h",
                           i, pred_s, mis_s, rdy_s, addr_s, exp_pred, exp_mis, exp_rdy, exp_addr);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    reset_s = 1'b1; m_reset(); tick(); reset_s = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    reset_s = 1'b1; m_reset(); tick(); reset_s = 1'b0;
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, $urandom, 32'h0, 1'b1, 1'($urandom));
      checks++;
      if (rdy_s !== 1'b0 || mis_s !== 1'b0 || pred_s !== 1'b0) begin
        errors++; $display("FAIL resweep %0d: got rdy=%b mis=%b pred=%b expected 0 0 0", i, rdy_s, mis_s, pred_s);
      end
      tick();
    end
    drive(1'b1, 32'h80, 32'h0, 1'b0, 1'b0);
    checks++;
    if (rdy_s !== 1'b1 || pred_s !== exp_pred) begin
      errors++; $display("FAIL resweep_ready: got rdy=%b pred=%b expected 1 %b", rdy_s, pred_s, exp_pred);
    end
    tick();
    reset_s = 1'b1; m_reset();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (mis_s !== 1'b0 || rdy_s !== 1'b0) begin
      errors++; $display("FAIL run_reset: got mis=%b rdy=%b expected 0 0", mis_s, rdy_s);
    end
    tick(); reset_s = 1'b0;
    for (int i = 0; i < 256; i++) tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    checks++;
    if (rdy_s !== 1'b1 || mis_s !== 1'b0) begin
      errors++; $display("FAIL discarded_record: got rdy=%b mis=%b expected 1 0", rdy_s, mis_s);
    end
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h80 + 32'(i * 4), 32'h0, 1'(i & 1), 1'($urandom));
      checks++;
      if (pred_s !== exp_pred || mis_s !== exp_mis) begin
        errors++; $display("FAIL ghr_cleared %0d: got pred=%b mis=%b expected %b %b", i, pred_s, mis_s, exp_pred, exp_mis);
      end
      tick();
    end
  endtask

  task automatic test_small_config();
    bit exp_p [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    bit exp_m [9] = '{0, 0, 0, 0, 0, 1, 1, 1, 1};
    @(posedge clk); #1;
    reset2_s = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      checks++;
      if (rdy2_s !== 1'b0) begin
        errors++; $display("FAIL small_sweep %0d: got rdy=%b expected 0", i, rdy2_s);
      end
      @(posedge clk); #1;
    end
    // Five taken then four not-taken at pc 0x40: counter 4 -> 7 (held) -> 3
    for (int k = 0; k < 9; k++) begin
      dec2_s = 1'b1; pc2_s = 32'h40; uv2_s = 1'b0;
      @(negedge clk);
      checks++;
      if (rdy2_s !== 1'b1 || pred2_s !== exp_p[k]) begin
        errors++; $display("FAIL small_pred %0d: got rdy=%b pred=%b expected 1 %b", k, rdy2_s, pred2_s, exp_p[k]);
      end
      @(posedge clk); #1;
      dec2_s = 1'b0; uv2_s = 1'b1; act2_s = (k < 5);
      @(negedge clk);
      checks++;
      if (mis2_s !== exp_m[k]) begin
        errors++; $display("FAIL small_mis %0d: got %b expected %b", k, mis2_s, exp_m[k]);
      end
      @(posedge clk); #1;
    end
    dec2_s = 1'b1; pc2_s = 32'hFFFF_FF40; uv2_s = 1'b0;
    @(negedge clk);
    checks++;
    if (pred2_s !== 1'b0 || addr2_s !== 32'h0000_0040) begin
      errors++; $display("FAIL small_final: got pred=%b addr=%h expected 0 00000040", pred2_s, addr2_s);
    end
    @(posedge clk); #1;
    dec2_s = 1'b0;
  endtask

  initial begin
    test_reset();
    test_local_sat();
    test_chooser();
    test_same_cycle();
    test_no_pending();
    test_random();
    test_reset_mid();
    test_small_config();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
